// File: rtl/tv_pkg.sv
// -----------------------------------------------------------------------------
// tv_pkg: shared types and helpers for the test-vector capture recorder.
//   tv_state_e : recorder FSM states (IDLE, CAPTURE, DRAIN, DONE), 2 bits
//   tv_pack    : builds one captured vector with the {dut_in, dut_out} layout.
//                Benches call the same function, so the layout is defined once.
//                The inputs are zero-extended to TV_MAX_W bits each. out_w is
//                the real width of the output field. The caller keeps the low
//                in_w+out_w bits of the result.
// -----------------------------------------------------------------------------
package tv_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    DRAIN   = 2'd2,
    DONE    = 2'd3
  } tv_state_e;

  // Widest supported single field (dut_in or dut_out).
  localparam int TV_MAX_W = 32;

  function automatic logic [2*TV_MAX_W-1:0] tv_pack(
    input logic [TV_MAX_W-1:0] in_v,
    input logic [TV_MAX_W-1:0] out_v,
    input int unsigned         out_w
  );
    logic [2*TV_MAX_W-1:0] w_vec;
    w_vec = ({{TV_MAX_W{1'b0}}, in_v} << out_w) | {{TV_MAX_W{1'b0}}, out_v};
    return w_vec;
  endfunction

endpackage

// File: rtl/tv_buffer.sv
// -----------------------------------------------------------------------------
// tv_buffer: DEPTH x W register file used as the capture store.
//   clk      : write clock
//   i_we     : write enable; i_wdata is written to mem[i_waddr] at the rising edge
//   i_waddr  : write address
//   i_wdata  : write data
//   i_raddr  : read address (asynchronous read)
//   o_rdata  : mem[i_raddr]
// The array has no reset. After a reset, old contents stay until they are
// overwritten.
// -----------------------------------------------------------------------------
module tv_buffer #(
  parameter  int W     = 16,
  parameter  int DEPTH = 16,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [W-1:0]  i_wdata,
  input  logic [AW-1:0] i_raddr,
  output logic [W-1:0]  o_rdata
);

  logic [W-1:0] r_mem [DEPTH];

  // Synchronous write port
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/tv_capture_recorder.sv
// -----------------------------------------------------------------------------
// tv_capture_recorder: records {dut_in, dut_out} on each sample_en strobe while
// armed. After capture ends, it drains the entries in order over a
// valid/ready stream.
//   clk        : clock; all state updates on the rising edge
//   reset      : asynchronous active-low reset
//   start      : arms a new capture (honoured in IDLE or DONE)
//   stop       : ends capture early (honoured in CAPTURE)
//   sample_en  : sample dut_in/dut_out this cycle
//   dut_in     : observed DUT input vector
//   dut_out    : observed DUT output vector
//   rd_ready   : consumer accepts rd_data
//   rd_valid   : rd_data valid (high throughout DRAIN)
//   rd_data    : {dut_in, dut_out} of the current entry
//   rd_last    : current entry is the final captured one
//   count      : entries captured this run (held until the next start)
//   busy       : CAPTURE or DRAIN
//   overflow   : sticky; a sample_en arrived during DRAIN
//   done       : one-cycle pulse in DONE
// -----------------------------------------------------------------------------
module tv_capture_recorder
  import tv_pkg::*;
#(
  parameter  int IN_W  = 8,
  parameter  int OUT_W = 8,
  parameter  int DEPTH = 16,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  stop,
  input  logic                  sample_en,
  input  logic [IN_W-1:0]       dut_in,
  input  logic [OUT_W-1:0]      dut_out,
  input  logic                  rd_ready,
  output logic                  rd_valid,
  output logic [IN_W+OUT_W-1:0] rd_data,
  output logic                  rd_last,
  output logic [AW:0]           count,
  output logic                  busy,
  output logic                  overflow,
  output logic                  done
);

  localparam int            DW       = IN_W + OUT_W;
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
  localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);

  tv_state_e     r_state;
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;
  logic          r_rd_valid;
  logic          r_rd_last;
  logic          r_busy;
  logic          r_overflow;
  logic          r_done;

  logic                  w_we;
  logic [2*TV_MAX_W-1:0] w_pack_full;
  logic [DW-1:0]         w_wdata;
  logic [DW-1:0]         w_rdata;
  logic [AW:0]           w_cnt_inc;
  logic [AW:0]           w_cnt_next;
  logic                  w_end_capture;
  logic [AW:0]           w_last_idx;
  logic [AW:0]           w_rd_next_ext;
  logic                  w_pack_unused;

  assign w_pack_full   = tv_pack(TV_MAX_W'(dut_in), TV_MAX_W'(dut_out), OUT_W);
  assign w_wdata       = w_pack_full[DW-1:0];
  assign w_pack_unused = ^w_pack_full[2*TV_MAX_W-1:DW];

  assign w_we          = (r_state == CAPTURE) & sample_en;
  assign w_cnt_inc     = r_count + CNT_ONE;
  assign w_cnt_next    = sample_en ? w_cnt_inc : r_count;
  // Capture ends on stop (after any same-cycle sample) or on the write that fills the buffer.
  assign w_end_capture = stop | (sample_en & (w_cnt_inc == CNT_FULL));
  assign w_last_idx    = r_count - CNT_ONE;
  assign w_rd_next_ext = {1'b0, r_rd_ptr} + CNT_ONE;

  tv_buffer #(
    .W     (DW),
    .DEPTH (DEPTH)
  ) u_buffer (
    .clk     (clk),
    .i_we    (w_we),
    .i_waddr (r_wr_ptr),
    .i_wdata (w_wdata),
    .i_raddr (r_rd_ptr),
    .o_rdata (w_rdata)
  );

  // Recorder FSM with pointers, count and registered status flags
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= IDLE;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_rd_valid <= 1'b0;
      r_rd_last  <= 1'b0;
      r_busy     <= 1'b0;
      r_overflow <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE, DONE: begin
          if (start) begin
            r_state    <= CAPTURE;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
            r_busy     <= 1'b1;
          end else begin
            r_state <= IDLE;
          end
        end
        CAPTURE: begin
          if (sample_en) begin
            r_wr_ptr <= r_wr_ptr + PTR_ONE;
            r_count  <= w_cnt_inc;
          end
          if (w_end_capture) begin
            if (w_cnt_next == '0) begin
              // Nothing captured: skip the drain.
              r_state <= DONE;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
            end else begin
              r_state    <= DRAIN;
              r_rd_valid <= 1'b1;
              r_rd_last  <= (w_cnt_next == CNT_ONE);
            end
          end
        end
        DRAIN: begin
          if (sample_en) begin
            r_overflow <= 1'b1;
          end
          if (rd_ready) begin
            r_rd_ptr <= r_rd_ptr + PTR_ONE;
            if (r_rd_last) begin
              r_state    <= DONE;
              r_rd_valid <= 1'b0;
              r_rd_last  <= 1'b0;
              r_busy     <= 1'b0;
              r_done     <= 1'b1;
            end else begin
              r_rd_last <= (w_rd_next_ext == w_last_idx);
            end
          end
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign rd_valid = r_rd_valid;
  assign rd_data  = w_rdata;
  assign rd_last  = r_rd_last;
  assign count    = r_count;
  assign busy     = r_busy;
  assign overflow = r_overflow;
  assign done     = r_done;

endmodule

// File: tb/tb_tv_capture_recorder.sv
// -----------------------------------------------------------------------------
// tb_tv_capture_recorder: directed scenarios and randomized capture/drain runs
// for tv_capture_recorder (IN_W=8, OUT_W=8, DEPTH=4). The reference model is a
// queue of expected entries plus an expected overflow flag.
// -----------------------------------------------------------------------------
module tb_tv_capture_recorder;
  import tv_pkg::*;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic        sample_en = 1'b0;
  logic [7:0]  dut_in = 8'h00;
  logic [7:0]  dut_out = 8'h00;
  logic        rd_ready = 1'b0;
  logic        rd_valid;
  logic [15:0] rd_data;
  logic        rd_last;
  logic [2:0]  count;
  logic        busy;
  logic        overflow;
  logic        done;

  int checks = 0;
  int errors = 0;

  logic [15:0] exp_q[$];
  logic        exp_ovf;

  tv_capture_recorder #(.IN_W(8), .OUT_W(8), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .start(start), .stop(stop), .sample_en(sample_en),
    .dut_in(dut_in), .dut_out(dut_out), .rd_ready(rd_ready), .rd_valid(rd_valid),
    .rd_data(rd_data), .rd_last(rd_last), .count(count), .busy(busy),
    .overflow(overflow), .done(done)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] pk(input logic [7:0] a, input logic [7:0] b);
    logic [63:0] v;
    v = tv_pack(32'(a), 32'(b), 8);
    return v[15:0];
  endfunction

  task automatic test_reset();
    reset = 1'b0;
    #3;
    checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL reset_rd_valid got %0b want 0", rd_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %0b want 0", busy); end
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL reset_count got %0d want 0", count); end
    checks++; if (overflow !== 1'b0 || done !== 1'b0 || rd_last !== 1'b0) begin errors++; $display("FAIL reset_flags got ovf=%0b done=%0b last=%0b want 0 0 0", overflow, done, rd_last); end
    tick();
    reset = 1'b1;
    tick();
  endtask

  task automatic test_full_capture();
    start = 1'b1; tick(); start = 1'b0;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL full_busy got %0b want 1", busy); end
    for (int i = 0; i < 4; i++) begin
      sample_en = 1'b1; dut_in = 8'(i + 1); dut_out = 8'(8'hA1 + i); tick();
    end
    sample_en = 1'b0; rd_ready = 1'b1;
    checks++; if (count !== 3'd4) begin errors++; $display("FAIL full_count got %0d want 4", count); end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (rd_valid !== 1'b1 || rd_data !== {8'(i + 1), 8'(8'hA1 + i)} || rd_last !== (i == 3) || done !== 1'b0) begin
        errors++; $display("FAIL full_drain%0d got v=%0b d=%h l=%0b dn=%0b want 1 %h %0b 0", i, rd_valid, rd_data, rd_last, done, {8'(i + 1), 8'(8'hA1 + i)}, (i == 3));
      end
      tick();
    end
    rd_ready = 1'b0;
    checks++; if (done !== 1'b1 || rd_valid !== 1'b0 || overflow !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL full_done got dn=%0b v=%0b ovf=%0b busy=%0b want 1 0 0 0", done, rd_valid, overflow, busy); end
    tick();
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL full_done_pulse got %0b want 0", done); end
  endtask

  task automatic test_backpressure();
    start = 1'b1; tick(); start = 1'b0;
    sample_en = 1'b1; dut_in = 8'h10; dut_out = 8'h55; tick();
    dut_in = 8'h11; dut_out = 8'h66; tick();
    sample_en = 1'b0; stop = 1'b1; tick(); stop = 1'b0;
    rd_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      checks++; if (rd_valid !== 1'b1 || rd_data !== 16'h1055 || rd_last !== 1'b0) begin errors++; $display("FAIL bp_hold%0d got v=%0b d=%h l=%0b want 1 1055 0", i, rd_valid, rd_data, rd_last); end
      tick();
    end
    rd_ready = 1'b1;
    checks++; if (rd_data !== 16'h1055 || rd_last !== 1'b0) begin errors++; $display("FAIL bp_first got d=%h l=%0b want 1055 0", rd_data, rd_last); end
    tick();
    checks++; if (rd_valid !== 1'b1 || rd_data !== 16'h1166 || rd_last !== 1'b1) begin errors++; $display("FAIL bp_second got v=%0b d=%h l=%0b want 1 1166 1", rd_valid, rd_data, rd_last); end
    tick(); rd_ready = 1'b0;
    checks++; if (done !== 1'b1 || count !== 3'd2) begin errors++; $display("FAIL bp_done got dn=%0b cnt=%0d want 1 2", done, count); end
    tick();
  endtask

  task automatic test_stop_with_sample();
    start = 1'b1; tick(); start = 1'b0;
    sample_en = 1'b1; dut_in = 8'h20; dut_out = 8'hAA; tick();
    stop = 1'b1; dut_in = 8'h22; dut_out = 8'hBB; tick();
    stop = 1'b0; sample_en = 1'b0; rd_ready = 1'b1;
    checks++; if (count !== 3'd2) begin errors++; $display("FAIL stopsmp_count got %0d want 2", count); end
    checks++; if (rd_data !== 16'h20AA || rd_last !== 1'b0) begin errors++; $display("FAIL stopsmp_first got d=%h l=%0b want 20aa 0", rd_data, rd_last); end
    tick();
    checks++; if (rd_data !== 16'h22BB || rd_last !== 1'b1) begin errors++; $display("FAIL stopsmp_last got d=%h l=%0b want 22bb 1", rd_data, rd_last); end
    tick(); rd_ready = 1'b0;
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL stopsmp_done got %0b want 1", done); end
    tick();
  endtask

  task automatic test_empty_run();
    start = 1'b1; tick(); start = 1'b0;
    stop = 1'b1; tick(); stop = 1'b0;
    checks++; if (done !== 1'b1 || rd_valid !== 1'b0 || busy !== 1'b0 || count !== 3'd0) begin errors++; $display("FAIL empty_done got dn=%0b v=%0b busy=%0b cnt=%0d want 1 0 0 0", done, rd_valid, busy, count); end
    tick();
    checks++; if (done !== 1'b0 || rd_valid !== 1'b0) begin errors++; $display("FAIL empty_after got dn=%0b v=%0b want 0 0", done, rd_valid); end
  endtask

  task automatic test_overflow_ignored_start();
    start = 1'b1; tick(); start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      sample_en = 1'b1; dut_in = 8'(8'h30 + i); dut_out = 8'(8'hC0 + i); tick();
    end
    rd_ready = 1'b0; sample_en = 1'b1; start = 1'b1; tick();
    sample_en = 1'b0; start = 1'b0;
    checks++; if (overflow !== 1'b1 || busy !== 1'b1 || rd_valid !== 1'b1 || rd_data !== 16'h30C0 || count !== 3'd4) begin
      errors++; $display("FAIL ovf_drain got ovf=%0b busy=%0b v=%0b d=%h cnt=%0d want 1 1 1 30c0 4", overflow, busy, rd_valid, rd_data, count);
    end
    rd_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      checks++; if (rd_data !== {8'(8'h30 + i), 8'(8'hC0 + i)}) begin errors++; $display("FAIL ovf_data%0d got %h want %h", i, rd_data, {8'(8'h30 + i), 8'(8'hC0 + i)}); end
      tick();
    end
    rd_ready = 1'b0;
    checks++; if (done !== 1'b1 || overflow !== 1'b1) begin errors++; $display("FAIL ovf_sticky got dn=%0b ovf=%0b want 1 1", done, overflow); end
    start = 1'b1; tick(); start = 1'b0;
    checks++; if (overflow !== 1'b0 || busy !== 1'b1 || count !== 3'd0) begin errors++; $display("FAIL ovf_clear got ovf=%0b busy=%0b cnt=%0d want 0 1 0", overflow, busy, count); end
    stop = 1'b1; tick(); stop = 1'b0;
    tick();
  endtask

  task automatic test_async_reset();
    start = 1'b1; tick(); start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      sample_en = 1'b1; dut_in = 8'(8'h40 + i); dut_out = 8'(8'hD0 + i); tick();
    end
    sample_en = 1'b0; stop = 1'b1; tick(); stop = 1'b0;
    rd_ready = 1'b1; tick(); rd_ready = 1'b0;
    #2 reset = 1'b0;
    #1;
    checks++; if (rd_valid !== 1'b0 || busy !== 1'b0 || count !== 3'd0) begin errors++; $display("FAIL arst_now got v=%0b busy=%0b cnt=%0d want 0 0 0", rd_valid, busy, count); end
    #1 reset = 1'b1;
    tick();
    checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL arst_idle got busy=%0b dn=%0b want 0 0", busy, done); end
    start = 1'b1; tick(); start = 1'b0;
    sample_en = 1'b1; dut_in = 8'h77; dut_out = 8'hEE; tick();
    sample_en = 1'b0; stop = 1'b1; tick(); stop = 1'b0;
    checks++; if (rd_valid !== 1'b1 || rd_data !== 16'h77EE || rd_last !== 1'b1 || count !== 3'd1) begin errors++; $display("FAIL arst_restart got v=%0b d=%h l=%0b cnt=%0d want 1 77ee 1 1", rd_valid, rd_data, rd_last, count); end
    rd_ready = 1'b1; tick(); rd_ready = 1'b0;
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL arst_done got %0b want 1", done); end
    tick();
  endtask

  task automatic test_random_runs(input int runs);
    for (int r = 0; r < runs; r++) begin
      bit ended;
      int cyc;
      exp_q.delete();
      exp_ovf = 1'b0;
      start = 1'b1; tick(); start = 1'b0;
      ended = 1'b0; cyc = 0;
      while (!ended) begin
        sample_en = 1'($urandom_range(0, 1));
        stop = ($urandom_range(0, 5) == 0) || (cyc == 40);
        dut_in = 8'($urandom); dut_out = 8'($urandom);
        if (sample_en) exp_q.push_back(pk(dut_in, dut_out));
        if (stop || exp_q.size() == DEPTH) ended = 1'b1;
        tick(); cyc++;
      end
      sample_en = 1'b0; stop = 1'b0;
      checks++; if (count !== 3'(exp_q.size())) begin errors++; $display("FAIL rnd%0d_count got %0d want %0d", r, count, exp_q.size()); end
      cyc = 0;
      while (exp_q.size() > 0 && cyc < 100) begin
        checks++;
        if (rd_valid !== 1'b1 || rd_data !== exp_q[0] || rd_last !== (exp_q.size() == 1) || done !== 1'b0) begin
          errors++; $display("FAIL rnd%0d_drain got v=%0b d=%h l=%0b dn=%0b want 1 %h %0b 0", r, rd_valid, rd_data, rd_last, done, exp_q[0], (exp_q.size() == 1));
        end
        rd_ready = 1'($urandom_range(0, 1));
        sample_en = ($urandom_range(0, 7) == 0);
        if (sample_en) exp_ovf = 1'b1;
        if (rd_ready) void'(exp_q.pop_front());
        tick(); cyc++;
      end
      rd_ready = 1'b0; sample_en = 1'b0;
      if (exp_q.size() > 0) begin
        errors++; $display("FAIL rnd%0d_timeout got %0d entries left want 0", r, exp_q.size());
      end
      checks++; if (done !== 1'b1 || rd_valid !== 1'b0 || busy !== 1'b0 || overflow !== exp_ovf) begin
        errors++; $display("FAIL rnd%0d_end got dn=%0b v=%0b busy=%0b ovf=%0b want 1 0 0 %0b", r, done, rd_valid, busy, overflow, exp_ovf);
      end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_full_capture();
    test_backpressure();
    test_stop_with_sample();
    test_empty_run();
    test_overflow_ignored_start();
    test_async_reset();
    test_random_runs(40);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
